// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, 1-cycle-latency memory between the CPU fetch and data
// ports, steering read data back to its owner and guarding fetch against starvation.
module mem_port_arbiter #(
    parameter int unsigned POLICY   = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        im_req,
    input  logic [31:0] im_address,
    output logic        im_grant,
    output logic        im_valid,
    output logic [31:0] im_data,
    input  logic        dm_req,
    input  logic        dm_write,
    input  logic [3:0]  dm_width,
    input  logic [31:0] dm_address,
    input  logic [31:0] dm_data_in,
    output logic        dm_grant,
    output logic        dm_valid,
    output logic [31:0] dm_data,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_width,
    output logic        mem_write_en,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in,
    output logic [3:0]  debug_starve_cnt,
    output logic        debug_rr_last,
    output logic [1:0]  debug_resp_owner
);

    // Handshake: a requester holds *_req and its operands stable until *_grant is seen
    // high in the same cycle; a granted read returns *_valid/*_data exactly one cycle later.
    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_FETCH = 2'd1,
        OWNER_DATA  = 2'd2
    } owner_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] starve_cnt, starve_cnt_next;
    logic       rr_last, rr_last_next;
    owner_t     resp_owner, resp_owner_next;
    logic       grant_fetch, grant_data;

    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (reset) begin
            if (im_req && !dm_req) begin
                grant_fetch = 1'b1;
            end else if (!im_req && dm_req) begin
                grant_data = 1'b1;
            end else if (im_req && dm_req) begin
                if (starve_cnt == MAX_WAIT_C) begin
                    grant_fetch = 1'b1;
                end else if (POLICY == 1) begin
                    grant_data = 1'b1;
                end else if (rr_last) begin
                    // data won last time, so fetch takes its turn
                    grant_fetch = 1'b1;
                end else begin
                    grant_data = 1'b1;
                end
            end
        end
    end

    always_comb begin
        starve_cnt_next = starve_cnt;
        rr_last_next    = rr_last;
        resp_owner_next = OWNER_NONE;
        if (grant_fetch) begin
            starve_cnt_next = 4'd0;
            rr_last_next    = 1'b0;
            resp_owner_next = OWNER_FETCH;
        end else if (im_req && (starve_cnt < MAX_WAIT_C)) begin
            starve_cnt_next = starve_cnt + 4'd1;
        end
        if (grant_data) begin
            rr_last_next    = 1'b1;
            resp_owner_next = dm_write ? OWNER_NONE : OWNER_DATA;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
            rr_last    <= 1'b1;
            resp_owner <= OWNER_NONE;
        end else begin
            starve_cnt <= starve_cnt_next;
            rr_last    <= rr_last_next;
            resp_owner <= resp_owner_next;
        end
    end

    always_comb begin
        mem_address  = 32'd0;
        mem_width    = 4'd0;
        mem_write_en = 1'b0;
        mem_data_out = 32'd0;
        if (grant_fetch) begin
            mem_address = im_address;
            mem_width   = 4'd4;
        end else if (grant_data) begin
            mem_address  = dm_address;
            mem_width    = dm_width;
            mem_write_en = dm_write;
            mem_data_out = dm_data_in;
        end
    end

    assign im_grant = grant_fetch;
    assign dm_grant = grant_data;
    assign im_valid = (resp_owner == OWNER_FETCH);
    assign dm_valid = (resp_owner == OWNER_DATA);
    assign im_data  = im_valid ? mem_data_in : 32'd0;
    assign dm_data  = dm_valid ? mem_data_in : 32'd0;

    assign debug_starve_cnt = starve_cnt;
    assign debug_rr_last    = rr_last;
    assign debug_resp_owner = resp_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance share the
// same requester stimulus, each backed by its own byte-addressed memory model.
module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clock;
    logic        reset;
    logic        im_req;
    logic [31:0] im_address;
    logic        dm_req;
    logic        dm_write;
    logic [3:0]  dm_width;
    logic [31:0] dm_address;
    logic [31:0] dm_data_in;

    logic        im_grant_o     [2];
    logic        im_valid_o     [2];
    logic [31:0] im_data_o      [2];
    logic        dm_grant_o     [2];
    logic        dm_valid_o     [2];
    logic [31:0] dm_data_o      [2];
    logic [31:0] mem_address_o  [2];
    logic [3:0]  mem_width_o    [2];
    logic        mem_write_en_o [2];
    logic [31:0] mem_data_out_o [2];
    logic [31:0] mem_rdata      [2];
    logic [3:0]  starve_o       [2];
    logic        rr_o           [2];
    logic [1:0]  owner_o        [2];

    // instance 0: round-robin, instance 1: data has fixed priority
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_port_arbiter #(.POLICY(gi), .MAX_WAIT(MAX_WAIT)) u_dut (
            .clock            (clock),
            .reset            (reset),
            .im_req           (im_req),
            .im_address       (im_address),
            .im_grant         (im_grant_o[gi]),
            .im_valid         (im_valid_o[gi]),
            .im_data          (im_data_o[gi]),
            .dm_req           (dm_req),
            .dm_write         (dm_write),
            .dm_width         (dm_width),
            .dm_address       (dm_address),
            .dm_data_in       (dm_data_in),
            .dm_grant         (dm_grant_o[gi]),
            .dm_valid         (dm_valid_o[gi]),
            .dm_data          (dm_data_o[gi]),
            .mem_address      (mem_address_o[gi]),
            .mem_width        (mem_width_o[gi]),
            .mem_write_en     (mem_write_en_o[gi]),
            .mem_data_out     (mem_data_out_o[gi]),
            .mem_data_in      (mem_rdata[gi]),
            .debug_starve_cnt (starve_o[gi]),
            .debug_rr_last    (rr_o[gi]),
            .debug_resp_owner (owner_o[gi])
        );
    end

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- memory models (registered read, little-endian) ----------------
    logic [7:0] mem_b   [2][0:1023];
    logic [7:0] ref_mem [0:1023];

    function automatic logic width_ok(input logic [3:0] w);
        return (w == 4'd1) || (w == 4'd2) || (w == 4'd4);
    endfunction

    function automatic logic [31:0] mem_read(input int i, input logic [31:0] addr, input logic [3:0] w);
        logic [31:0] r;
        r = 32'd0;
        if (width_ok(w))
            for (int b = 0; b < int'(w); b++) r[8*b +: 8] = mem_b[i][10'(addr + 32'(b))];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input logic [3:0] w);
        logic [31:0] r;
        r = 32'd0;
        if (width_ok(w))
            for (int b = 0; b < int'(w); b++) r[8*b +: 8] = ref_mem[10'(addr + 32'(b))];
        return r;
    endfunction

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            mem_rdata[i] <= mem_write_en_o[i] ? 32'd0 : mem_read(i, mem_address_o[i], mem_width_o[i]);
            if (mem_write_en_o[i] && width_ok(mem_width_o[i]))
                for (int b = 0; b < int'(mem_width_o[i]); b++)
                    mem_b[i][10'(mem_address_o[i] + 32'(b))] <= mem_data_out_o[i][8*b +: 8];
        end
    end

    // ---------------- scoreboard state ----------------
    logic [32:0] exp_q [2][$];   // {owner_is_data, data}
    int          ref_starve [2];
    logic        ref_rr     [2];
    logic        obs_im_g   [2];
    logic        obs_dm_g   [2];
    logic        obs_we     [2];
    logic [3:0]  obs_width  [2];
    int          n_checks;
    int          n_errors;

    task automatic release_reset();
        im_req = 1'b0; im_address = 32'd0;
        dm_req = 1'b0; dm_write = 1'b0; dm_width = 4'd0; dm_address = 32'd0; dm_data_in = 32'd0;
        exp_q[0].delete(); exp_q[1].delete();
        ref_starve[0] = 0; ref_starve[1] = 0;
        ref_rr[0] = 1'b1;  ref_rr[1] = 1'b1;
        reset = 1'b1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        exp_q[0].delete(); exp_q[1].delete();
        repeat (2) @(posedge clock);
        #1;
        release_reset();
    endtask

    // Drives one cycle's requests, checks grants / memory port / responses at the
    // falling edge, then queues the read data each instance should return next cycle.
    task automatic drive_half(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [3:0] dwid, input logic [31:0] da, input logic [31:0] dd);
        logic        eg_im [2];
        logic        eg_dm [2];
        logic [31:0] x_addr, x_dout, x_imd, x_dmd;
        logic [3:0]  x_w;
        logic        x_we, x_imv, x_dmv;
        logic [32:0] e;
        im_req = ir; im_address = ia;
        dm_req = dr; dm_write = dw; dm_width = dwid; dm_address = da; dm_data_in = dd;
        for (int i = 0; i < 2; i++) begin
            eg_im[i] = 1'b0; eg_dm[i] = 1'b0;
            if (ir && !dr) eg_im[i] = 1'b1;
            else if (!ir && dr) eg_dm[i] = 1'b1;
            else if (ir && dr) begin
                if (ref_starve[i] == MAX_WAIT) eg_im[i] = 1'b1;
                else if (i == 1) eg_dm[i] = 1'b1;
                else if (ref_rr[i]) eg_im[i] = 1'b1;
                else eg_dm[i] = 1'b1;
            end
        end
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            obs_im_g[i] = im_grant_o[i]; obs_dm_g[i] = dm_grant_o[i];
            obs_we[i] = mem_write_en_o[i]; obs_width[i] = mem_width_o[i];
            n_checks++;
            if (im_grant_o[i] !== eg_im[i] || dm_grant_o[i] !== eg_dm[i]) begin
                n_errors++;
                $display("FAIL grant[%0d]: got im=%b dm=%b, expected im=%b dm=%b", i,
                         im_grant_o[i], dm_grant_o[i], eg_im[i], eg_dm[i]);
            end
            x_addr = 32'd0; x_w = 4'd0; x_we = 1'b0; x_dout = 32'd0;
            if (eg_im[i]) begin
                x_addr = ia; x_w = 4'd4;
            end else if (eg_dm[i]) begin
                x_addr = da; x_w = dwid; x_we = dw; x_dout = dd;
            end
            n_checks++;
            if (mem_address_o[i] !== x_addr || mem_width_o[i] !== x_w || mem_write_en_o[i] !== x_we ||
                (!eg_im[i] && mem_data_out_o[i] !== x_dout)) begin
                n_errors++;
                $display("FAIL mem_port[%0d]: got addr=%h w=%0d we=%b dout=%h, expected addr=%h w=%0d we=%b dout=%h",
                         i, mem_address_o[i], mem_width_o[i], mem_write_en_o[i], mem_data_out_o[i],
                         x_addr, x_w, x_we, x_dout);
            end
            x_imv = 1'b0; x_imd = 32'd0; x_dmv = 1'b0; x_dmd = 32'd0;
            if (exp_q[i].size() > 0) begin
                e = exp_q[i].pop_front();
                if (e[32]) begin x_dmv = 1'b1; x_dmd = e[31:0]; end
                else begin x_imv = 1'b1; x_imd = e[31:0]; end
            end
            n_checks++;
            if (im_valid_o[i] !== x_imv || im_data_o[i] !== x_imd ||
                dm_valid_o[i] !== x_dmv || dm_data_o[i] !== x_dmd) begin
                n_errors++;
                $display("FAIL response[%0d]: got im_valid=%b im_data=%h dm_valid=%b dm_data=%h, expected %b %h %b %h",
                         i, im_valid_o[i], im_data_o[i], dm_valid_o[i], dm_data_o[i], x_imv, x_imd, x_dmv, x_dmd);
            end
            if (eg_im[i]) exp_q[i].push_back({1'b0, ref_read(ia, 4'd4)});
            else if (eg_dm[i] && !dw) exp_q[i].push_back({1'b1, ref_read(da, dwid)});
            if (eg_im[i]) ref_starve[i] = 0;
            else if (ir && ref_starve[i] < MAX_WAIT) ref_starve[i]++;
            if (eg_im[i]) ref_rr[i] = 1'b0;
            else if (eg_dm[i]) ref_rr[i] = 1'b1;
        end
        if (dr && dw && eg_dm[0] && width_ok(dwid))
            for (int b = 0; b < int'(dwid); b++) ref_mem[10'(da + 32'(b))] = dd[8*b +: 8];
    endtask

    task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [3:0] dwid, input logic [31:0] da, input logic [31:0] dd);
        drive_half(ir, ia, dr, dw, dwid, da, dd);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        im_req = 1'b1; im_address = 32'h40;
        dm_req = 1'b1; dm_write = 1'b1; dm_width = 4'd4; dm_address = 32'h80; dm_data_in = 32'h1234_5678;
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({im_grant_o[i], dm_grant_o[i], im_valid_o[i], dm_valid_o[i], mem_write_en_o[i]} !== 5'b0) begin
                n_errors++;
                $display("FAIL reset_ctrl[%0d]: got img=%b dmg=%b imv=%b dmv=%b we=%b, expected all 0", i,
                         im_grant_o[i], dm_grant_o[i], im_valid_o[i], dm_valid_o[i], mem_write_en_o[i]);
            end
            n_checks++;
            if (im_data_o[i] !== 32'd0 || dm_data_o[i] !== 32'd0 || mem_address_o[i] !== 32'd0 ||
                mem_data_out_o[i] !== 32'd0 || mem_width_o[i] !== 4'd0) begin
                n_errors++;
                $display("FAIL reset_data[%0d]: got imd=%h dmd=%h addr=%h dout=%h w=%0d, expected all 0", i,
                         im_data_o[i], dm_data_o[i], mem_address_o[i], mem_data_out_o[i], mem_width_o[i]);
            end
            n_checks++;
            if (starve_o[i] !== 4'd0 || rr_o[i] !== 1'b1 || owner_o[i] !== 2'd0) begin
                n_errors++;
                $display("FAIL reset_state[%0d]: got starve=%0d rr=%b owner=%0d, expected 0 1 0", i,
                         starve_o[i], rr_o[i], owner_o[i]);
            end
        end
        @(posedge clock);
        #1;
        release_reset();
    endtask

    task automatic test_fetch_only();
        logic [31:0] words [3];
        words[0] = 32'h0040_0793; words[1] = 32'h0140_006F; words[2] = 32'h0030_0713;
        for (int k = 0; k < 3; k++) cycle(1'b0, 32'd0, 1'b1, 1'b1, 4'd4, 32'(4 * k), words[k]);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'(4 * k), 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_im_g[i] !== 1'b1 || im_valid_o[i] !== 1'b1 || im_data_o[i] !== words[k] ||
                    dm_valid_o[i] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL fetch_only[%0d] k=%0d: got grant=%b valid=%b data=%h dm_valid=%b, expected 1 1 %h 0",
                             i, k, obs_im_g[i], im_valid_o[i], im_data_o[i], dm_valid_o[i], words[k]);
                end
            end
        end
        idle();
    endtask

    task automatic test_store_load();
        cycle(1'b0, 32'd0, 1'b1, 1'b1, 4'd4, 32'h100, 32'hDEAD_BEEF);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_we[i] !== 1'b1 || dm_valid_o[i] !== 1'b0) begin
                n_errors++;
                $display("FAIL store[%0d]: got we=%b dm_valid=%b, expected 1 0", i, obs_we[i], dm_valid_o[i]);
            end
        end
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 4'd4, 32'h100, 32'd0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_we[i] !== 1'b0 || dm_valid_o[i] !== 1'b1 || dm_data_o[i] !== 32'hDEAD_BEEF) begin
                n_errors++;
                $display("FAIL load[%0d]: got we=%b dm_valid=%b dm_data=%h, expected 0 1 deadbeef", i,
                         obs_we[i], dm_valid_o[i], dm_data_o[i]);
            end
        end
        idle();
    endtask

    task automatic test_narrow_loads();
        logic [31:0] exp_d [3];
        logic [3:0]  ws    [3];
        logic [31:0] as    [3];
        exp_d[0] = 32'h0000_0033; ws[0] = 4'd1; as[0] = 32'h101;
        exp_d[1] = 32'h0000_1122; ws[1] = 4'd2; as[1] = 32'h102;
        exp_d[2] = 32'h0000_0000; ws[2] = 4'd3; as[2] = 32'h100;
        cycle(1'b0, 32'd0, 1'b1, 1'b1, 4'd4, 32'h100, 32'h1122_3344);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 32'd0, 1'b1, 1'b0, ws[k], as[k], 32'd0);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_width[i] !== ws[k] || dm_valid_o[i] !== 1'b1 || dm_data_o[i] !== exp_d[k]) begin
                    n_errors++;
                    $display("FAIL narrow_load[%0d] k=%0d: got w=%0d valid=%b data=%h, expected %0d 1 %h", i, k,
                             obs_width[i], dm_valid_o[i], dm_data_o[i], ws[k], exp_d[k]);
                end
            end
        end
        idle();
    endtask

    task automatic test_contention();
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            cycle(1'b1, 32'h0, 1'b1, 1'b0, 4'd4, 32'h100, 32'd0);
            n_checks++;
            if (obs_im_g[0] !== (c % 2 == 0) || obs_dm_g[0] !== (c % 2 == 1)) begin
                n_errors++;
                $display("FAIL round_robin c=%0d: got im=%b dm=%b, expected im=%b dm=%b", c,
                         obs_im_g[0], obs_dm_g[0], (c % 2 == 0), (c % 2 == 1));
            end
            n_checks++;
            if (obs_im_g[1] !== (c == 4) || obs_dm_g[1] !== (c != 4)) begin
                n_errors++;
                $display("FAIL fixed_prio c=%0d: got im=%b dm=%b, expected im=%b dm=%b", c,
                         obs_im_g[1], obs_dm_g[1], (c == 4), (c != 4));
            end
            if (c == 3 || c == 4) begin
                n_checks++;
                if (starve_o[1] !== ((c == 3) ? 4'd4 : 4'd0)) begin
                    n_errors++;
                    $display("FAIL starve_cnt c=%0d: got %0d, expected %0d", c, starve_o[1], (c == 3) ? 4 : 0);
                end
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 16; c++) begin
            int unsigned mode;
            int unsigned k;
            logic [3:0]  w;
            logic [31:0] a;
            mode = $urandom_range(0, 2);
            k = $urandom_range(0, 2);
            w = 4'(1 << k);
            a = 32'h100 + 32'($urandom_range(0, (4 >> k) - 1) << k);
            if (mode == 0) cycle(1'b1, 32'(4 * $urandom_range(0, 2)), 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
            else if (mode == 1) cycle(1'b0, 32'd0, 1'b1, 1'b0, w, a, 32'd0);
            else idle();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (im_valid_o[i] !== (mode == 0) || dm_valid_o[i] !== (mode == 1)) begin
                    n_errors++;
                    $display("FAIL back_to_back[%0d] c=%0d: got im_valid=%b dm_valid=%b, mode=%0d", i, c,
                             im_valid_o[i], dm_valid_o[i], mode);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_read();
        drive_half(1'b1, 32'h4, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        reset = 1'b0;
        exp_q[0].delete(); exp_q[1].delete();
        im_req = 1'b0; im_address = 32'd0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (im_valid_o[i] !== 1'b0 || im_data_o[i] !== 32'd0 || dm_valid_o[i] !== 1'b0 ||
                im_grant_o[i] !== 1'b0 || mem_width_o[i] !== 4'd0 || owner_o[i] !== 2'd0) begin
                n_errors++;
                $display("FAIL reset_mid_read[%0d]: got imv=%b imd=%h dmv=%b img=%b w=%0d owner=%0d, expected all 0",
                         i, im_valid_o[i], im_data_o[i], dm_valid_o[i], im_grant_o[i], mem_width_o[i], owner_o[i]);
            end
        end
        repeat (2) @(posedge clock);
        #1;
        release_reset();
        cycle(1'b1, 32'h8, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_im_g[i] !== 1'b1 || im_valid_o[i] !== 1'b1 || im_data_o[i] !== 32'h0030_0713) begin
                n_errors++;
                $display("FAIL post_reset_fetch[%0d]: got grant=%b valid=%b data=%h, expected 1 1 00300713", i,
                         obs_im_g[i], im_valid_o[i], im_data_o[i]);
            end
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_fetch_only();
        test_store_load();
        test_narrow_loads();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported `Memory` instance between the CPU32 instruction-fetch port and its data port.
- Unified-memory builds need this because program and data live in one array.
- Arbitrates per cycle, drives the shared memory port, tracks the memory's 1-cycle registered read latency, and steers returned read data to the requester that owns it.
- Includes an anti-starvation counter so fetch cannot be locked out by back-to-back data traffic.

Parameters:
- POLICY, 1, 0 = round-robin between fetch and data; 1 = data has fixed priority over fetch.
- MAX_WAIT, 4, consecutive cycles fetch may be refused while requesting before it is forced a grant (1..15).

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low (0 = in reset)
- im_req  input  1  fetch request (read, word, width 4)
- im_address  input  32  fetch byte address
- im_grant  output  1  fetch request accepted this cycle
- im_valid  output  1  im_data valid (cycle after im_grant)
- im_data  output  32  fetch read data
- dm_req  input  1  data request
- dm_write  input  1  1 = store, 0 = load
- dm_width  input  4  1/2/4 bytes, passed through
- dm_address  input  32  data byte address
- dm_data_in  input  32  store data
- dm_grant  output  1  data request accepted this cycle
- dm_valid  output  1  dm_data valid (cycle after a load grant)
- dm_data  output  32  load read data
- mem_address  output  32  to Memory address
- mem_width  output  4  to Memory width (0 when idle)
- mem_write_en  output  1  to Memory write_en
- mem_data_out  output  32  to Memory data_in
- mem_data_in  input  32  from Memory data_out

Behaviour:
- Grant logic:
  - Grants are combinational from requests plus registered state.
  - At most one grant per cycle.
  - A request not granted must be held stable by the requester until granted.
- Granted fetch drives: mem_address=im_address, mem_width=4, mem_write_en=0.
- Granted data drives: mem_address=dm_address, mem_width=dm_width, mem_write_en=dm_write, mem_data_out=dm_data_in.
- No grant drives: mem_address=0, mem_width=0, mem_write_en=0, mem_data_out=0.
- Selection order, first match wins:
  - (a) Only one requester active: it wins.
  - (b) Both active and starve_cnt == MAX_WAIT: fetch wins.
  - (c) Both active, POLICY=1: data wins.
  - (d) Both active, POLICY=0: the requester not granted most recently wins (rr_last register; 0 = fetch, 1 = data).
- Starvation counter (starve_cnt, 4-bit):
  - Increments each cycle im_req=1 and im_grant=0, saturating at MAX_WAIT.
  - Clears on im_grant.
  - Holds when im_req=0.
- rr_last updates only on a grant.
- Response tracking:
  - Register resp_owner (NONE/FETCH/DATA) captures the owner of each granted read.
  - A data write sets NONE.
- Cycle N+1 after a granted read:
  - FETCH: im_valid=1, im_data=mem_data_in.
  - DATA: dm_valid=1, dm_data=mem_data_in.
  - The non-owning data output is 0.
- Read latency is exactly 1 cycle. Reads may be back-to-back every cycle.
- Stores produce no valid pulse; completion is the grant cycle itself.
- Reset (reset=0), asynchronous:
  - im_grant=dm_grant=0; all mem_* outputs idle; im_valid=dm_valid=0; im_data=dm_data=0.
  - starve_cnt=0, rr_last=1 (fetch preferred first), resp_owner=NONE.
- Reset asserted with a read in flight: the response is dropped and no valid is emitted after release.
- First cycle after reset release: grants resume normally.
- Simultaneous requests on the same address: the arbitration rules apply unchanged. The loser sees memory contents updated by the winner's store on its later grant.
- dm_width values other than 1/2/4 are passed through unchanged. Memory produces 0/no write; dm_valid still pulses with data 0 for loads.

Test Plan:
- Fetch only: im_req=1 at 0x0, 0x4, 0x8 on consecutive cycles, memory preloaded 0x00400793, 0x0140006F, 0x00300713 -> im_grant=1 each cycle; im_valid=1 one cycle later with those words in order; dm_valid=0 throughout.
- POLICY=1, MAX_WAIT=4, im_req and dm_req (loads) held high for 8 cycles -> dm_grant cycles 0-3, im_grant cycle 4, dm_grant cycles 5-7; starve_cnt returns to 0 after cycle 4.
- POLICY=0, both requesting continuously -> grants alternate fetch, data, fetch, data starting with fetch after reset; im_valid/dm_valid alternate one cycle behind.
- Store then load: dm_write=1, width 4, address 0x100, data 0xDEADBEEF, then load 0x100 -> mem_write_en=1 only on store grant; no dm_valid for the store; load gives dm_valid=1, dm_data=0xDEADBEEF.
- Byte load: dm_width=1, address 0x101 after word 0x11223344 stored at 0x100 -> dm_data=0x00000033.
- Reset mid-read: grant fetch load at cycle N, pull reset low before edge N+1, release at N+3 -> im_valid never asserts; all outputs 0 during reset; first post-reset request granted same cycle.
